// File: rtl/ax_btb_update_sender.sv
// Write-side source for the approximate BTB: filters taken approximate branches from all
// integer lanes into a small FIFO and emits one BTB write request per cycle (valid/ready).
module ax_btb_update_sender #(
  parameter int LANES      = 2,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [LANES-1:0]            br_valid,
  input  logic [LANES-1:0]            br_taken,
  input  logic [LANES-1:0]            br_is_ap,
  input  logic [LANES-1:0]            br_is_cond,
  input  logic [LANES*ADDR_WIDTH-1:0] br_addr,
  input  logic [LANES*ADDR_WIDTH-1:0] br_next,
  output logic                        upd_valid,
  input  logic                        upd_ready,
  output logic [INDEX_BITS-1:0]       upd_index,
  output logic [TAG_BITS-1:0]         upd_tag,
  output logic [ADDR_WIDTH-3:0]       upd_target,
  output logic                        upd_is_cond,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic [7:0]                  drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [ADDR_WIDTH-3:0] target;
    logic                  is_cond;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic [LANES-1:0] cand;
  logic [LANES-1:0] keep;
  logic             pop;
  logic [CW-1:0]    free;
  logic [CW-1:0]    n_push;
  logic [7:0]       n_drop;
  logic [8:0]       drop_sum;
  logic [PW-1:0]    wr_ptr;
  entry_t           lane_entry;
  entry_t           head_entry;
  logic             unused_next;

  // A lower lane is squashed when a higher lane carries the same branch PC this cycle.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cand[i] = br_valid[i] & br_taken[i] & br_is_ap[i];
    end
    keep = cand;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (cand[j] && (br_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == br_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
          keep[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    pop        = (count_q != '0) && upd_ready;
    free       = CW'(DEPTH) - count_q + CW'(pop);
    mem_d      = mem_q;
    n_push     = '0;
    n_drop     = '0;
    lane_entry = '0;
    wr_ptr     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (keep[i]) begin
        if (n_push < free) begin
          lane_entry.index   = br_addr[i*ADDR_WIDTH + 2 +: INDEX_BITS];
          lane_entry.tag     = br_addr[i*ADDR_WIDTH + INDEX_BITS + 2 +: TAG_BITS];
          lane_entry.target  = br_next[i*ADDR_WIDTH + 2 +: ADDR_WIDTH - 2];
          lane_entry.is_cond = br_is_cond[i];
          wr_ptr             = tail_q + n_push[PW-1:0];
          if (!flush) begin
            mem_d[wr_ptr] = lane_entry;
          end
          n_push = n_push + CW'(1);
        end else begin
          n_drop = n_drop + 8'd1;
        end
      end
    end
    drop_sum = {1'b0, drop_cnt_q} + {1'b0, n_drop};
    // Flush discards the queue and everything presented alongside it without counting drops.
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      drop_cnt_d = drop_cnt_q;
    end else begin
      head_d     = head_q + PW'(pop);
      tail_d     = tail_q + n_push[PW-1:0];
      count_d    = count_q + n_push - CW'(pop);
      drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Payload is masked while empty so unreset storage never leaks onto the port.
  always_comb begin
    upd_valid   = (count_q != '0);
    head_entry  = mem_q[head_q];
    upd_index   = upd_valid ? head_entry.index   : '0;
    upd_tag     = upd_valid ? head_entry.tag     : '0;
    upd_target  = upd_valid ? head_entry.target  : '0;
    upd_is_cond = upd_valid ? head_entry.is_cond : 1'b0;
  end

  always_comb begin
    unused_next = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      unused_next = unused_next ^ (^br_next[i*ADDR_WIDTH +: 2]);
    end
  end

  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign drop_cnt = drop_cnt_q;

endmodule
